// File: rtl/restador_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and
// the bit-counter width helper.
package restador_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/restador_serial_restador.sv
// Combinational 1-bit full subtractor: D = a - b - Bin, Bout = borrow out.
module restador (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/restador_serial.sv
// Bit-serial WIDTH-bit subtractor (D = a - b - Bin, LSB first) built on a
// single full-subtractor cell, with a start/busy/done handshake.
module restador_serial
  import restador_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_d;
  logic cell_bout;

  restador u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .Bin  (br_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    res_d   = res_q;
    bout_d  = bout_q;
    v_d     = v_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = Bin;
          sr_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d  = {cell_d, sr_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        // br_q here is the borrow into the MSB, so V = borrow-in ^ borrow-out.
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          res_d   = {cell_d, sr_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          v_d     = br_q ^ cell_bout;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = res_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_restador_serial.sv
// Randomized self-checking bench for restador_serial (WIDTH=8) against an
// arithmetic reference model, plus an exhaustive check of the 1-bit cell.
module tb_restador_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;

  logic ca, cb, cbin, cd, cbo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] hold_d;
  logic         hold_b;
  logic         hold_v;

  restador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  restador u_cell_ut (
    .a    (ca),
    .b    (cb),
    .Bin  (cbin),
    .D    (cd),
    .Bout (cbo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int s8(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - 256 : int'(x);
  endfunction

  // Reference: unsigned difference gives D/Bout, signed range gives V.
  task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       output logic [W-1:0] ed, output logic eb, output logic ev);
    int u;
    int s;
    u  = int'(oa) - int'(ob) - int'(obin);
    s  = s8(oa) - s8(ob) - int'(obin);
    ed = W'(u & 255);
    eb = (u < 0);
    ev = (s > 127) || (s < -128);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input bit noise);
    logic [W-1:0] ed;
    logic         eb;
    logic         ev;
    model(oa, ob, obin, ed, eb, ev);
    a = oa; b = ob; Bin = obin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      check_eq("busy_shift", {31'd0, busy}, 32'd1);
      check_eq("done_shift", {31'd0, done}, 32'd0);
      check_eq("hold_D", {24'd0, D}, {24'd0, hold_d});
      if (noise && c >= 2) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
        Bin   = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_done", {31'd0, busy}, 32'd1);
    check_eq("D", {24'd0, D}, {24'd0, ed});
    check_eq("Bout", {31'd0, Bout}, {31'd0, eb});
    check_eq("V", {31'd0, V}, {31'd0, ev});
    hold_d = ed; hold_b = eb; hold_v = ev;
    tick();
    check_eq("done_after", {31'd0, done}, 32'd0);
    check_eq("busy_after", {31'd0, busy}, 32'd0);
    check_eq("hold_D_idle", {24'd0, D}, {24'd0, hold_d});
  endtask

  initial begin
    logic [2:0]   v3;
    int           r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      ca = v3[2]; cb = v3[1]; cbin = v3[0];
      #1;
      r = int'(ca) - int'(cb) - int'(cbin);
      check_eq("cell_D", {31'd0, cd}, {31'd0, 1'(r & 1)});
      check_eq("cell_Bout", {31'd0, cbo}, {31'd0, (r < 0)});
    end

    rst = 1'b1; start = 1'b0; a = '0; b = '0; Bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_D", {24'd0, D}, 32'd0);
    check_eq("rst_Bout", {31'd0, Bout}, 32'd0);
    check_eq("rst_V", {31'd0, V}, 32'd0);
    hold_d = '0; hold_b = 1'b0; hold_v = 1'b0;

    run_op(8'h5A, 8'h23, 1'b0, 1'b0);
    check_eq("tp1_D", {24'd0, hold_d}, 32'h37);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b1);
    run_op(8'hC3, 8'h3C, 1'b1, 1'b1);

    // start held high: one operation every W+2 cycles
    a = 8'h5A; b = 8'h23; Bin = 1'b0; start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      check_eq("b2b_done", {31'd0, done}, {31'd0, (c % 10 == 9)});
      if (c == 29) begin
        check_eq("b2b_D", {24'd0, D}, 32'h37);
        check_eq("b2b_Bout", {31'd0, Bout}, 32'd0);
      end
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    hold_d = 8'h37; hold_b = 1'b0; hold_v = 1'b0;

    // reset in cycle 4 of an operation
    a = 8'h10; b = 8'h20; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_D", {24'd0, D}, 32'd0);
    check_eq("mid_rst_Bout", {31'd0, Bout}, 32'd0);
    check_eq("mid_rst_V", {31'd0, V}, 32'd0);
    hold_d = '0; hold_b = 1'b0; hold_v = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_eq("mid_rst_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    run_op(8'h5A, 8'h23, 1'b0, 1'b0);

    for (int n = 0; n < 2500; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 16 == 0) ra = 8'h80;
      if (n % 16 == 1) rb = 8'h80;
      if (n % 16 == 2) ra = 8'h7F;
      run_op(ra, rb, 1'($urandom), (n % 4 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
